// File: rtl/dct_da_seq.sv
// Bit-serial distributed-arithmetic DCT stage: one 4-input dot product per DW cycles using an 8-entry coefficient ROM.
// Latency DW+1 edges from operand handshake to out_valid; result held until out_ready, operand intake stalls while a result is pending.
module dct_da_seq #(
   parameter int DW = 16,
   parameter int RW = 16,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_x0,
   input  logic [DW-1:0] in_x1,
   input  logic [DW-1:0] in_x2,
   input  logic [DW-1:0] in_x3,
   output logic          rom_cs,
   output logic [2:0]    rom_addr,
   input  logic [RW-1:0] rom_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_z,
   output logic          busy
);
   localparam int BW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [BW-1:0] B_LAST = BW'(DW - 1);

   logic [1:0]    r_state;
   logic [1:0]    r_rst_sync;
   logic [DW-1:0] r_x0, r_x1, r_x2, r_x3;
   logic [BW-1:0] r_b;
   logic [AW-1:0] r_acc;

   logic          w_s;
   logic          w_last;
   logic          w_load;
   logic [2:0]    w_addr;
   logic [AW-1:0] w_ext;
   logic [AW-1:0] w_term;
   logic [AW-1:0] w_shift;
   logic [AW-1:0] w_acc_nxt;

   // Offset-binary DA: a set sign bit selects the mirrored ROM entry and negates it.
   assign w_s       = r_x0[r_b];
   assign w_addr    = {r_x1[r_b], r_x2[r_b], r_x3[r_b]} ^ {3{w_s}};
   assign w_ext     = {{(AW-RW){rom_data[RW-1]}}, rom_data};
   assign w_term    = w_s ? -w_ext : w_ext;
   assign w_shift   = w_term << r_b;
   assign w_last    = (r_b == B_LAST);
   // The MSB slice carries negative weight in two's complement.
   assign w_acc_nxt = w_last ? (r_acc - w_shift) : (r_acc + w_shift);

   assign in_ready  = r_rst_sync[1] & ~flush &
                      ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
   assign w_load    = in_valid & in_ready;

   assign rom_cs    = (r_state == S_RUN);
   assign rom_addr  = rom_cs ? w_addr : 3'b000;
   assign out_valid = (r_state == S_DONE);
   assign out_z     = r_acc;
   assign busy      = (r_state == S_RUN) | (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rst_sync <= 2'b00;
         r_x0       <= '0;
         r_x1       <= '0;
         r_x2       <= '0;
         r_x3       <= '0;
         r_b        <= '0;
         r_acc      <= '0;
      end else begin
         // Intake is held off until the ROM side has seen two clean edges out of reset.
         r_rst_sync <= {r_rst_sync[0], 1'b1};
         if (flush) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_x3    <= '0;
            r_b     <= '0;
            r_acc   <= '0;
         end else if (w_load) begin
            r_state <= S_RUN;
            r_x0    <= in_x0;
            r_x1    <= in_x1;
            r_x2    <= in_x2;
            r_x3    <= in_x3;
            r_b     <= '0;
            r_acc   <= '0;
         end else begin
            case (r_state)
               S_RUN: begin
                  r_acc <= w_acc_nxt;
                  if (w_last) begin
                     r_b     <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_b <= r_b + BW'(1);
                  end
               end
               S_DONE: begin
                  if (out_ready) r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
